// File: rtl/seg_scroll_animator.sv
// Multi-digit active-low 7-segment driver. On each accepted load the old characters
// scroll vertically out while the new characters scroll in, in half-digit steps.
module seg_scroll_animator #(
    parameter int unsigned NUM_DIGITS  = 4,
    parameter int unsigned STEP_CYCLES = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [7*NUM_DIGITS-1:0] new_chars,
    input  logic                    dir_up,
    input  logic [NUM_DIGITS-1:0]   anim_mask,
    output logic                    ready,
    output logic                    busy,
    output logic                    done,
    output logic [7*NUM_DIGITS-1:0] disp_out
);

    localparam int unsigned W  = 7 * NUM_DIGITS;
    localparam int unsigned TW = $clog2(STEP_CYCLES + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(STEP_CYCLES - 1);

    typedef enum logic {
        ST_IDLE,
        ST_ANIM
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        frame_q, frame_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [W-1:0]      cur_q, cur_d;
    logic [W-1:0]      disp_q, disp_d;
    logic [W-1:0]      old_q, old_d;
    logic [W-1:0]      tgt_q, tgt_d;
    logic              dir_q, dir_d;
    logic [NUM_DIGITS-1:0] mask_q, mask_d;
    logic              done_q, done_d;

    // Segment bit order per digit is {a,b,c,d,e,f,g}; a lit segment is 0.
    function automatic logic [6:0] shift_up(input logic [6:0] s, input logic [1:0] k);
        logic [6:0] r;
        case (k)
            2'd0:    r = s;
            2'd1:    r = {s[0], s[4], 3'b111, s[2], s[3]};
            2'd2:    r = {s[3], 6'b111111};
            default: r = '1;
        endcase
        return r;
    endfunction

    function automatic logic [6:0] shift_down(input logic [6:0] s, input logic [1:0] k);
        logic [6:0] r;
        case (k)
            2'd0:    r = s;
            2'd1:    r = {2'b11, s[5], s[0], s[1], 1'b1, s[6]};
            2'd2:    r = {3'b111, s[6], 3'b111};
            default: r = '1;
        endcase
        return r;
    endfunction

    function automatic logic [W-1:0] merge_frame(
        input logic [W-1:0]          old_c,
        input logic [W-1:0]          tgt_c,
        input logic                  up,
        input logic [NUM_DIGITS-1:0] mask,
        input logic [1:0]            k
    );
        logic [W-1:0] r;
        logic [6:0]   o;
        logic [6:0]   n;
        r = '1;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            o = old_c[7*i +: 7];
            n = tgt_c[7*i +: 7];
            if (!mask[i])
                r[7*i +: 7] = n;
            else if (up)
                r[7*i +: 7] = shift_up(o, k) & shift_down(n, 2'd3 - k);
            else
                r[7*i +: 7] = shift_down(o, k) & shift_up(n, 2'd3 - k);
        end
        return r;
    endfunction

    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        timer_d = timer_q;
        cur_d   = cur_q;
        disp_d  = disp_q;
        old_d   = old_q;
        tgt_d   = tgt_q;
        dir_d   = dir_q;
        mask_d  = mask_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                disp_d  = cur_q;
                frame_d = 2'd0;
                if (load) begin
                    old_d   = cur_q;
                    tgt_d   = new_chars;
                    dir_d   = dir_up;
                    mask_d  = anim_mask;
                    disp_d  = merge_frame(cur_q, new_chars, dir_up, anim_mask, 2'd1);
                    frame_d = 2'd1;
                    timer_d = '0;
                    state_d = ST_ANIM;
                end
            end
            ST_ANIM: begin
                if (timer_q == TIMER_LAST) begin
                    timer_d = '0;
                    if (frame_q == 2'd1) begin
                        frame_d = 2'd2;
                        disp_d  = merge_frame(old_q, tgt_q, dir_q, mask_q, 2'd2);
                    end else begin
                        // Final frame is always the target, so it is loaded directly.
                        frame_d = 2'd0;
                        disp_d  = tgt_q;
                        cur_d   = tgt_q;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            frame_q <= 2'd0;
            timer_q <= '0;
            cur_q   <= '1;
            disp_q  <= '1;
            old_q   <= '1;
            tgt_q   <= '1;
            dir_q   <= 1'b0;
            mask_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            frame_q <= frame_d;
            timer_q <= timer_d;
            cur_q   <= cur_d;
            disp_q  <= disp_d;
            old_q   <= old_d;
            tgt_q   <= tgt_d;
            dir_q   <= dir_d;
            mask_q  <= mask_d;
            done_q  <= done_d;
        end
    end

    assign ready    = (state_q == ST_IDLE);
    assign busy     = ~ready;
    assign done     = done_q;
    assign disp_out = disp_q;

endmodule

// File: tb/tb_seg_scroll_animator.sv
// Bench for seg_scroll_animator: directed scenarios plus random loads, checked every
// cycle against a geometric model of the vertical scroll (segments placed on rows/columns).
module tb_seg_scroll_animator;

    localparam int unsigned N = 4;
    localparam int unsigned S = 2;
    localparam int unsigned W = 7 * N;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          load = 1'b0;
    logic [W-1:0]  new_chars = '0;
    logic          dir_up = 1'b0;
    logic [N-1:0]  anim_mask = '0;
    logic          ready;
    logic          busy;
    logic          done;
    logic [W-1:0]  disp_out;

    int unsigned   n_cmp = 0;
    int unsigned   n_bad = 0;
    logic [W-1:0]  cur_m;
    logic [6:0]    d0_log [5];

    always #5 clk = ~clk;

    seg_scroll_animator #(
        .NUM_DIGITS (N),
        .STEP_CYCLES(S)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .new_chars(new_chars),
        .dir_up   (dir_up),
        .anim_mask(anim_mask),
        .ready    (ready),
        .busy     (busy),
        .done     (done),
        .disp_out (disp_out)
    );

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish (compared %0d)", n_cmp);
        $fatal(1);
    end

    // Segment geometry, index 0..6 = a..g: half-digit row (0 top .. 4 bottom) and column.
    function automatic int seg_row(int i);
        case (i)
            0: return 0;
            1: return 1;
            2: return 3;
            3: return 4;
            4: return 3;
            5: return 1;
            default: return 2;
        endcase
    endfunction

    function automatic int seg_col(int i);
        case (i)
            1, 2:    return 1;
            4, 5:    return 2;
            default: return 0;
        endcase
    endfunction

    function automatic logic [6:0] ref_shift(logic [6:0] x, bit up, int k);
        logic [6:0] r = '1;
        int off = up ? 2 * k : -2 * k;
        for (int i = 0; i < 7; i++)
            for (int j = 0; j < 7; j++)
                if (seg_col(j) == seg_col(i) && seg_row(j) == seg_row(i) + off)
                    r[6-i] = x[6-j];
        return r;
    endfunction

    function automatic logic [W-1:0] ref_frame(logic [W-1:0] old_c, logic [W-1:0] tgt_c,
                                               bit up, logic [N-1:0] mask, int k);
        logic [W-1:0] r;
        for (int d = 0; d < N; d++) begin
            if (!mask[d])
                r[7*d +: 7] = tgt_c[7*d +: 7];
            else
                r[7*d +: 7] = ref_shift(old_c[7*d +: 7], up, k) & ref_shift(tgt_c[7*d +: 7], !up, 3 - k);
        end
        return r;
    endfunction

    task automatic chk(string tag, logic [W-1:0] obs, logic [W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(string tag);
        chk({tag, "_disp"}, disp_out, cur_m);
        chk({tag, "_ready"}, W'(ready), W'(1'b1));
        chk({tag, "_busy"}, W'(busy), W'(1'b0));
        chk({tag, "_done"}, W'(done), W'(1'b0));
    endtask

    task automatic idle(int n);
        repeat (n) begin
            @(negedge clk);
            chk_idle("idle");
        end
    endtask

    // Called just after a negedge; returns at the negedge where the final frame is shown.
    task automatic run_anim(logic [W-1:0] chars, bit dir, logic [N-1:0] mask, bit meddle);
        logic [W-1:0] old_m;
        logic [W-1:0] exp;
        int k;
        load      = 1'b1;
        new_chars = chars;
        dir_up    = dir;
        anim_mask = mask;
        chk("ready_before_load", W'(ready), W'(1'b1));
        old_m = cur_m;
        @(posedge clk);
        #1;
        load      = meddle;
        new_chars = W'($urandom);
        dir_up    = 1'($urandom);
        anim_mask = N'($urandom);
        for (int c = 0; c <= 2 * int'(S); c++) begin
            @(negedge clk);
            k = c / int'(S) + 1;
            exp = ref_frame(old_m, chars, dir, mask, k);
            chk($sformatf("frame%0d_disp", k), disp_out, exp);
            chk($sformatf("frame%0d_ready", k), W'(ready), W'(k == 3));
            chk($sformatf("frame%0d_busy", k), W'(busy), W'(k != 3));
            chk($sformatf("frame%0d_done", k), W'(done), W'(k == 3));
            if (c < 5) d0_log[c] = disp_out[6:0];
        end
        cur_m = chars;
        load  = 1'b0;
    endtask

    task automatic chk_d0(string tag, logic [6:0] f1, logic [6:0] f2, logic [6:0] f3);
        logic [6:0] exp_seq [5];
        exp_seq = '{f1, f1, f2, f2, f3};
        for (int i = 0; i < 5; i++)
            chk($sformatf("%s_step%0d", tag, i), W'(d0_log[i]), W'(exp_seq[i]));
    endtask

    initial begin
        logic [W-1:0] c_zero;
        logic [W-1:0] c_one;
        logic [W-1:0] c_rand;
        bit           meddle;

        // Reset held for two cycles
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        cur_m = '1;
        chk_idle("reset");
        rst_n = 1'b1;
        idle(2);

        // Digit 0: '0' -> '1' scrolling up
        c_zero = W'($urandom);
        c_zero[6:0] = 7'b0000001;
        c_one = W'($urandom);
        c_one[6:0] = 7'b1001111;
        run_anim(c_zero, 1'b1, '1, 1'b0);
        idle(1);
        run_anim(c_one, 1'b1, '1, 1'b0);
        chk_d0("d0_up", 7'b1011100, 7'b0101111, 7'b1001111);
        idle(1);

        // Digit 0: '0' -> '1' scrolling down
        run_anim(c_zero, 1'b0, '1, 1'b0);
        idle(1);
        run_anim(c_one, 1'b0, '1, 1'b0);
        chk_d0("d0_down", 7'b1101010, 7'b1010111, 7'b1001111);
        idle(1);

        // Partial animation mask
        run_anim(W'($urandom), 1'($urandom), 4'b0101, 1'b0);
        idle(1);

        // Same characters again still run the full scroll
        run_anim(cur_m, 1'b1, '1, 1'b0);
        idle(1);

        // Load held high with changing data during the animation is ignored
        run_anim(W'($urandom), 1'b1, '1, 1'b1);
        idle(2);

        // Reset during frame 2 aborts without a done pulse
        c_rand = W'($urandom);
        load = 1'b1;
        new_chars = c_rand;
        dir_up = 1'b1;
        anim_mask = '1;
        @(posedge clk);
        #1;
        load = 1'b0;
        repeat (S + 1) @(negedge clk);
        chk("abort_frame2_disp", disp_out, ref_frame(cur_m, c_rand, 1'b1, '1, 2));
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        cur_m = '1;
        chk_idle("abort_reset");
        rst_n = 1'b1;
        idle(2 * S + 2);

        // Random loads, including back-to-back accepts at the final-frame edge
        for (int it = 0; it < 30; it++) begin
            meddle = ($urandom_range(0, 3) == 0);
            run_anim(W'($urandom), 1'($urandom), N'($urandom), meddle);
            if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 3));
        end
        idle(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
